bsg_sync_stable_recv: RTL and testbench



---
 rtl/bsg_sync_stable_recv_pkg.sv | 34 +++
 rtl/bsg_gray_to_binary.sv | 24 ++
 rtl/bsg_sync_stable_recv.sv | 135 +++++++++++++
 tb/tb_bsg_sync_stable_recv.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_sync_stable_recv_pkg.sv
// bsg_sync_stable_recv_pkg
//   Shared types and elaboration helpers for the stable-value receiver.
//   - state_e             : filter state (IDLE, SETTLE)
//   - cnt_width()         : width of the saturating stability counter
//   - stable_cycles_*_lp  : legal bounds of stable_cycles_p
//   - stable_cycles_legal(): range check used at elaboration
package bsg_sync_stable_recv_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  localparam int unsigned stable_cycles_min_lp = 32'd1;
  localparam int unsigned stable_cycles_max_lp = 32'd15;

  // Counter must be able to hold 0..stable_cycles.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    int unsigned w;
    w = $clog2(stable_cycles + 32'd1);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

  function automatic bit stable_cycles_legal(input int unsigned stable_cycles);
    return (stable_cycles >= stable_cycles_min_lp) &&
           (stable_cycles <= stable_cycles_max_lp);
  endfunction

endpackage

// File: rtl/bsg_gray_to_binary.sv
// bsg_gray_to_binary
//   Purely combinational Gray-code to binary converter. Used by
//   bsg_sync_stable_recv only when BSG_SYNC_STABLE_RECV_GRAY_EN is defined.
// Ports:
//   gray_i   [width_p-1:0] Gray-coded input
//   binary_o [width_p-1:0] binary equivalent
module bsg_gray_to_binary #(
  parameter int width_p = 32
) (
  input  logic [width_p-1:0] gray_i,
  output logic [width_p-1:0] binary_o
);

  // MSB passes through; each lower binary bit is the XOR of all Gray bits above and at it.
  always_comb begin
    logic [width_p-1:0] bin_v;
    bin_v = gray_i;
    for (int i = width_p - 2; i >= 0; i--) begin
      bin_v[i] = bin_v[i+1] ^ gray_i[i];
    end
    binary_o = bin_v;
  end

endmodule

// File: rtl/bsg_sync_stable_recv.sv
// bsg_sync_stable_recv
//   Receive end of a multi-bit bus crossing a double-flop synchronizer.
//   Transient skewed codes are filtered: a new value is accepted only after
//   it has been sampled unchanged for stable_cycles_p cycles following its
//   first appearance. Each accepted value is offered once on v_o/yumi_i.
//   Optional build macro: BSG_SYNC_STABLE_RECV_GRAY_EN -- input is Gray code,
//   data_o carries the binary decode of the accepted value.
// Ports:
//   clk_i        destination-domain clock
//   reset_n_i    asynchronous active-low reset
//   sync_data_i  second synchronizer flop output [width_p-1:0]
//   v_o          data_o holds an accepted, unconsumed value
//   data_o       accepted value [width_p-1:0]
//   yumi_i       consumer takes data_o this cycle (only when v_o=1)
//   overrun_o    sticky: an accepted value replaced an unconsumed one
module bsg_sync_stable_recv #(
  parameter int width_p         = 32,
  parameter int stable_cycles_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] sync_data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i,
  output logic               overrun_o
);

  import bsg_sync_stable_recv_pkg::*;

  localparam int unsigned cnt_w_lp = cnt_width(stable_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(stable_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_sat_lp  = {cnt_w_lp{1'b1}};

  if (!stable_cycles_legal(stable_cycles_p)) begin : g_bad_stable_cycles
    $error("bsg_sync_stable_recv: stable_cycles_p out of range 1..15");
  end

  state_e               state_r, state_n_s;
  logic [width_p-1:0]   prev_r, prev_n_s;
  logic [width_p-1:0]   last_r, last_n_s;
  logic [cnt_w_lp-1:0]  cnt_r, cnt_n_s;
  logic                 accept_s;
  logic [width_p-1:0]   dec_s;

`ifdef BSG_SYNC_STABLE_RECV_GRAY_EN
  // Stability is judged on raw Gray bits; only the presented value is decoded.
  bsg_gray_to_binary #(
    .width_p (width_p)
  ) u_g2b (
    .gray_i   (sync_data_i),
    .binary_o (dec_s)
  );
`else
  assign dec_s = sync_data_i;
`endif

  // Filter state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      prev_r  <= {width_p{1'b0}};
      last_r  <= {width_p{1'b0}};
      cnt_r   <= {cnt_w_lp{1'b0}};
    end else begin
      state_r <= state_n_s;
      prev_r  <= prev_n_s;
      last_r  <= last_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Next-state logic of the stability filter; accept_s marks an accept event.
  always_comb begin
    state_n_s = state_r;
    prev_n_s  = prev_r;
    last_n_s  = last_r;
    cnt_n_s   = cnt_r;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync_data_i != last_r) begin
          prev_n_s  = sync_data_i;
          cnt_n_s   = {cnt_w_lp{1'b0}};
          state_n_s = SETTLE;
        end else begin
          state_n_s = IDLE;
        end
      end
      SETTLE: begin
        if (sync_data_i == last_r) begin
          // Glitch that reverted to the already-accepted value.
          state_n_s = IDLE;
        end else if (sync_data_i != prev_r) begin
          // Another intermediate code: restart counting from it.
          prev_n_s = sync_data_i;
          cnt_n_s  = {cnt_w_lp{1'b0}};
        end else if (cnt_r == cnt_last_lp) begin
          accept_s  = 1'b1;
          last_n_s  = sync_data_i;
          state_n_s = IDLE;
        end else if (cnt_r != cnt_sat_lp) begin
          cnt_n_s = cnt_r + cnt_w_lp'(1);
        end else begin
          cnt_n_s = cnt_r;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Output handshake register: accept wins over consume, overrun is sticky.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o       <= 1'b0;
      data_o    <= {width_p{1'b0}};
      overrun_o <= 1'b0;
    end else if (accept_s) begin
      v_o    <= 1'b1;
      data_o <= dec_s;
      if (v_o && !yumi_i) begin
        overrun_o <= 1'b1;
      end else begin
        overrun_o <= overrun_o;
      end
    end else if (v_o && yumi_i) begin
      v_o <= 1'b0;
    end else begin
      v_o <= v_o;
    end
  end

endmodule

// File: tb/tb_bsg_sync_stable_recv.sv
// tb_bsg_sync_stable_recv
//   Self-checking bench for bsg_sync_stable_recv (width_p=32, stable_cycles_p=3).
//   Per-cycle vector table plus hand sequences for reset mid-SETTLE and the
//   value-6 decode check; consumed values are checked against a queue of
//   expected accepts. Honors BSG_SYNC_STABLE_RECV_GRAY_EN for expectations.
module tb_bsg_sync_stable_recv;

  localparam int W = 32;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  sync_data;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi;
  logic          overrun_o;

  int n_cmp;
  int n_err;

  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [W-1:0] din;
    logic         yumi;
    logic         push;
    logic         exp_v;
    logic [W-1:0] exp_raw;
    logic         exp_ovr;
  } vec_t;

  vec_t vecs[$];

  bsg_sync_stable_recv #(
    .width_p         (W),
    .stable_cycles_p (3)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .sync_data_i (sync_data),
    .v_o         (v_o),
    .data_o      (data_o),
    .yumi_i      (yumi),
    .overrun_o   (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected presented value for a raw accepted bus value.
  function automatic logic [W-1:0] exp_map(input logic [W-1:0] raw);
    logic [W-1:0] b;
    b = raw;
`ifdef BSG_SYNC_STABLE_RECV_GRAY_EN
    for (int s = 1; s < W; s++) begin
      b = b ^ (raw >> s);
    end
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [W-1:0] ed, input logic eo);
    chk({tag, ".v"},    {31'd0, v_o},       {31'd0, ev});
    chk({tag, ".data"}, data_o,             ed);
    chk({tag, ".ovr"},  {31'd0, overrun_o}, {31'd0, eo});
  endtask

  // Drive one cycle of inputs at negedge; outputs are stable at return (#1 after posedge).
  task automatic step(input logic [W-1:0] din, input logic y, input logic push);
    logic [W-1:0] e;
    @(negedge clk);
    sync_data = din;
    yumi      = y;
    if (push) sb_q.push_back(exp_map(din));
    if (y) begin
      chk("yumi_needs_v", {31'd0, v_o}, 32'd1);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: consumed %h with nothing expected", data_o);
      end else begin
        n_cmp--;
        e = sb_q.pop_front();
        chk("sb_data", data_o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [W-1:0] din, input logic y, input logic push,
                     input logic ev, input logic [W-1:0] er, input logic eo);
    vec_t v;
    v.din = din; v.yumi = y; v.push = push;
    v.exp_v = ev; v.exp_raw = er; v.exp_ovr = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] va, vc;
    n_cmp = 0;
    n_err = 0;
    va = 32'hA5A5_0001;
    vc = 32'h0000_00C3;

    // din, yumi, push, exp_v, exp_raw, exp_ovr
    add(va, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    add(va, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    add(va, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    add(va, 1'b0, 1'b0, 1'b1, va,    1'b0);   // 3+1 cycles after first sample
    add(va, 1'b1, 1'b0, 1'b0, va,    1'b0);   // consumed
    add(32'h3, 1'b0, 1'b0, 1'b0, va, 1'b0);   // skew code
    add(32'h3, 1'b0, 1'b0, 1'b0, va, 1'b0);
    add(32'h7, 1'b0, 1'b1, 1'b0, va, 1'b0);   // final code restarts count
    add(32'h7, 1'b0, 1'b0, 1'b0, va, 1'b0);
    add(32'h7, 1'b0, 1'b0, 1'b0, va, 1'b0);
    add(32'h7, 1'b0, 1'b0, 1'b1, 32'h7, 1'b0);
    add(32'h7, 1'b1, 1'b0, 1'b0, 32'h7, 1'b0);
    add(32'h7, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0); // no re-accept
    add(32'h5, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0); // glitch ...
    add(32'h7, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0); // ... reverting to old value
    add(32'h7, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0);
    add(32'h9, 1'b0, 1'b1, 1'b0, 32'h7, 1'b0);
    add(32'h9, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0);
    add(32'h9, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0);
    add(32'h9, 1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
    add(32'hB0, 1'b0, 1'b1, 1'b1, 32'h9, 1'b0);
    add(32'hB0, 1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
    add(32'hB0, 1'b0, 1'b0, 1'b1, 32'h9, 1'b0);
    add(32'hB0, 1'b1, 1'b0, 1'b1, 32'hB0, 1'b0); // yumi with accept: no overrun
    add(32'hB0, 1'b1, 1'b0, 1'b0, 32'hB0, 1'b0);
    add(32'h11, 1'b0, 1'b0, 1'b0, 32'hB0, 1'b0);
    add(32'h11, 1'b0, 1'b0, 1'b0, 32'hB0, 1'b0);
    add(32'h11, 1'b0, 1'b0, 1'b0, 32'hB0, 1'b0);
    add(32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    add(32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0);
    add(32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    add(32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    add(32'h22, 1'b0, 1'b0, 1'b1, 32'h22, 1'b1); // overwrite -> overrun
    add(32'h22, 1'b1, 1'b0, 1'b0, 32'h22, 1'b1);
    add(32'h22, 1'b0, 1'b0, 1'b0, 32'h22, 1'b1); // overrun sticky

    // Reset with idle bus.
    reset_n   = 1'b0;
    sync_data = 32'h0;
    yumi      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("in_reset", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(32'h0, 1'b0, 1'b0);
      chk({31'd0, v_o}, {31'd0, v_o} & 32'h0, 32'h0) ;
    end
    chk_out("idle20", 1'b0, 32'h0, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].din, vecs[i].yumi, vecs[i].push);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_v, exp_map(vecs[i].exp_raw), vecs[i].exp_ovr);
    end

    // Reset asserted mid-SETTLE with cnt_r=2.
    step(vc, 1'b0, 1'b0);
    step(vc, 1'b0, 1'b0);
    step(vc, 1'b0, 1'b0);
    chk_out("pre_rst", 1'b0, exp_map(32'h22), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_q.push_back(exp_map(vc));
    @(posedge clk);
    #1;
    chk_out("rel0", 1'b0, 32'h0, 1'b0);
    step(vc, 1'b0, 1'b0);
    chk_out("rel1", 1'b0, 32'h0, 1'b0);
    step(vc, 1'b0, 1'b0);
    chk_out("rel2", 1'b0, 32'h0, 1'b0);
    step(vc, 1'b0, 1'b0);
    chk_out("rel3", 1'b1, exp_map(vc), 1'b0);
    step(vc, 1'b1, 1'b0);
    chk_out("rel_yumi", 1'b0, exp_map(vc), 1'b0);

    // Value 6 (Gray 6 decodes to 4 in the Gray build).
    step(32'h6, 1'b0, 1'b1);
    step(32'h6, 1'b0, 1'b0);
    step(32'h6, 1'b0, 1'b0);
    chk_out("six_wait", 1'b0, exp_map(vc), 1'b0);
    step(32'h6, 1'b0, 1'b0);
`ifdef BSG_SYNC_STABLE_RECV_GRAY_EN
    chk_out("six_acc", 1'b1, 32'h0000_0004, 1'b0);
`else
    chk_out("six_acc", 1'b1, 32'h0000_0006, 1'b0);
`endif
    step(32'h6, 1'b1, 1'b0);
    chk_out("six_yumi", 1'b0, exp_map(32'h6), 1'b0);

    chk("sb_leftover", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
